// File: rtl/alu_op_sequencer.sv
// Button-driven ALU sequencer: synchronises and debounces five buttons, issues ALU ops
// and captures the ALU result after a fixed latency.
module alu_op_sequencer #(
  parameter int unsigned DB_CYCLES   = 4,
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [4:0]       btn_in,
  input  logic [WIDTH-1:0] alu_result,
  output logic [2:0]       alu_control,
  output logic [1:0]       cantidad,
  output logic             alu_start,
  output logic [WIDTH-1:0] result_q,
  output logic             result_valid,
  output logic             busy
);

  localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned LatW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(DB_CYCLES - 1);
  localparam logic [LatW-1:0] LatInit = LatW'(ALU_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e          state_q, state_d;
  logic [4:0]      sync1_q, sync2_q;
  logic [4:0]      cand_q, cand_d;
  logic [4:0]      stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic            pending_q, pending_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [1:0]      cant_q, cant_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic            rv_q, rv_d;
  logic            evt;
  logic [4:0]      newest;

  // Shared debounce counter: any change of the synchronised vector restarts the count.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q < CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign evt      = (cnt_q == CntMax) && (cand_q != stable_q);
  assign stable_d = evt ? cand_q : stable_q;
  // A vector accepted on this very edge beats the previously latched one.
  assign newest   = evt ? cand_q : stable_q;

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    pending_d = pending_q;
    ctrl_d    = ctrl_q;
    cant_d    = cant_q;
    res_d     = res_q;
    rv_d      = rv_q;
    case (state_q)
      StIdle: begin
        if (evt) begin
          state_d = StLoad;
          ctrl_d  = {newest[4], newest[3], newest[0]};
          cant_d  = {newest[2], newest[1]};
          rv_d    = 1'b0;
        end
      end
      StLoad: begin
        state_d = StRun;
        lat_d   = LatInit;
        if (evt) pending_d = 1'b1;
      end
      StRun: begin
        if (lat_q == '0) begin
          res_d = alu_result;
          rv_d  = 1'b1;
          if (pending_q || evt) begin
            state_d   = StLoad;
            ctrl_d    = {newest[4], newest[3], newest[0]};
            cant_d    = {newest[2], newest[1]};
            pending_d = 1'b0;
            rv_d      = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          lat_d = lat_q - 1'b1;
          if (evt) pending_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      pending_q <= 1'b0;
      ctrl_q    <= '0;
      cant_q    <= '0;
      res_q     <= '0;
      rv_q      <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      pending_q <= pending_d;
      ctrl_q    <= ctrl_d;
      cant_q    <= cant_d;
      res_q     <= res_d;
      rv_q      <= rv_d;
    end
  end

  assign alu_control  = ctrl_q;
  assign cantidad     = cant_q;
  assign alu_start    = (state_q == StLoad) && ena;
  assign result_q     = res_q;
  assign result_valid = rv_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus queues expected ops, a negedge monitor
// checks each alu_start and the matching result capture.
module tb_alu_op_sequencer;

  localparam int unsigned DB  = 4;
  localparam int unsigned W   = 4;
  localparam int unsigned LAT = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic [4:0]   btn_in = '0;
  logic [W-1:0] alu_result = '0;
  logic [2:0]   alu_control;
  logic [1:0]   cantidad;
  logic         alu_start;
  logic [W-1:0] result_q;
  logic         result_valid;
  logic         busy;

  alu_op_sequencer #(
    .DB_CYCLES  (DB),
    .WIDTH      (W),
    .ALU_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .btn_in      (btn_in),
    .alu_result  (alu_result),
    .alu_control (alu_control),
    .cantidad    (cantidad),
    .alu_start   (alu_start),
    .result_q    (result_q),
    .result_valid(result_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ctrl;
    logic [1:0] cant;
    int         due;
  } op_t;

  op_t          exp_q[$];
  int           act = 0;   // active (ena=1) edges seen
  int           cyc = 0;   // all edges seen
  int           n_pass = 0;
  int           n_total = 0;
  logic         cap_pending = 1'b0;
  int           cap_act = 0;
  int           start_cyc = 0;
  int           cap_cyc = 0;
  logic [W-1:0] cap_val = '0;
  int           a, c0;

  function automatic logic [W-1:0] alu_model(input int n);
    return W'(n * 7 + 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ena) act <= act + 1;
  end

  // Monitor: the ALU stub output follows the active-edge count so capture timing is visible.
  always @(negedge clk) begin
    op_t  e;
    logic b2b;
    if (rst_n) begin
      if (cap_pending && act == cap_act) begin
        b2b = (exp_q.size() > 0) && (exp_q[0].due == act);
        chk("cap_result_q", 32'(result_q), 32'(cap_val));
        chk("cap_result_valid", 32'(result_valid), 32'(!b2b));
        chk("cap_busy", 32'(busy), 32'(b2b));
        chk("cap_b2b_start", 32'(alu_start), 32'(b2b));
        cap_pending = 1'b0;
        cap_cyc = cyc;
      end
      if (alu_start) begin
        chk("start_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("start_ctrl", 32'(alu_control), 32'(e.ctrl));
          chk("start_cant", 32'(cantidad), 32'(e.cant));
          chk("start_due", 32'(act), 32'(e.due));
          chk("start_rv_clear", 32'(result_valid), 32'd0);
          chk("start_busy", 32'(busy), 32'd1);
          cap_pending = 1'b1;
          cap_act = act + 1 + LAT;
          cap_val = alu_model(act + LAT);
          start_cyc = cyc;
        end
      end
      if (!ena) chk("start_gated", 32'(alu_start), 32'd0);
    end
    alu_result = alu_model(act);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_act(input int t);
    int guard = 0;
    while (act < t && guard < 500) begin
      step(1);
      guard++;
    end
    chk("wait_act_bound", 32'(act >= t), 32'd1);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() > 0 || cap_pending) && guard < 300) begin
      step(1);
      guard++;
    end
    chk("drained", 32'(exp_q.size() == 0 && !cap_pending), 32'd1);
    step(4);
  endtask

  task automatic push_op(input logic [2:0] ctrl, input logic [1:0] cant, input int due);
    op_t o;
    o.ctrl = ctrl;
    o.cant = cant;
    o.due  = due;
    exp_q.push_back(o);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 32'(alu_control), 32'd0);
    chk({tag, "_cant"}, 32'(cantidad), 32'd0);
    chk({tag, "_start"}, 32'(alu_start), 32'd0);
    chk({tag, "_result_q"}, 32'(result_q), 32'd0);
    chk({tag, "_rv"}, 32'(result_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    step(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(3);

    // Single op: 10001 -> ctrl 101, cant 00.
    a = act;
    btn_in = 5'b10001;
    push_op(3'b101, 2'b00, a + 3 + DB);
    drain();

    // Bounce between 00100 and 0, then hold 00100 -> one op with cant 10.
    for (int i = 0; i < 6; i++) begin
      btn_in = (i % 2 == 0) ? 5'b00100 : 5'b00000;
      step(2);
    end
    a = act;
    btn_in = 5'b00100;
    push_op(3'b000, 2'b10, a + 3 + DB);
    drain();

    // Change accepted mid-RUN -> back-to-back op with 01010.
    a = act;
    btn_in = 5'b00001;
    push_op(3'b001, 2'b00, a + 7);
    push_op(3'b010, 2'b01, a + 16);
    wait_act(a + 8);
    btn_in = 5'b01010;
    drain();

    // Two vectors accepted in one RUN collapse into one op using the second.
    a = act;
    btn_in = 5'b11000;
    push_op(3'b110, 2'b00, a + 7);
    push_op(3'b101, 2'b10, a + 16);
    wait_act(a + 4);
    btn_in = 5'b00110;
    wait_act(a + 8);
    btn_in = 5'b10101;
    drain();

    // ena low for 5 cycles during debounce and again during RUN.
    a = act;
    c0 = cyc;
    btn_in = 5'b10110;
    push_op(3'b100, 2'b11, a + 7);
    wait_act(a + 2);
    ena = 1'b0;
    step(5);
    ena = 1'b1;
    wait_act(a + 10);
    ena = 1'b0;
    step(5);
    ena = 1'b1;
    drain();
    chk("ena_start_cycle", 32'(start_cyc), 32'(c0 + 12));
    chk("ena_cap_cycle", 32'(cap_cyc), 32'(c0 + 26));

    // Reset asserted mid-RUN.
    a = act;
    btn_in = 5'b00011;
    push_op(3'b001, 2'b01, a + 7);
    wait_act(a + 10);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    btn_in = 5'b00000;
    exp_q.delete();
    cap_pending = 1'b0;
    #1;
    chk_all_zero("async_reset");
    step(3);
    rst_n = 1'b1;
    step(20);
    chk_all_zero("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
